encoder: RTL and testbench
==========================

# encoder

Radix-4 (modified Booth) recoder for an 8-bit two's-complement operand, used in the Goldschmidt divider's multiplier front end to drive partial-product selection. It splits the operand into four overlapping 3-bit groups and emits one signed-digit control triple per group: negate, select ×2, select ×1. Inputs are sampled and outputs are registered, so the block is a single pipeline stage.

## Interface
- No parameters. Operand width is fixed at 8 bits, giving 4 digits.
- clk       input   1  rising-edge clock
- rst       input   1  synchronous, active-high reset
- valid_in  input   1  x is valid this cycle
- x         input   8  operand, two's complement
- valid_out output  1  sdn1..sdn4 hold a new result
- sdn1      output  3  digit 0 (weight 4^0), from group {x[1],x[0],0}
- sdn2      output  3  digit 1 (weight 4^1), from group x[3:1]
- sdn3      output  3  digit 2 (weight 4^2), from group x[5:3]
- sdn4      output  3  digit 3 (weight 4^3), from group x[7:5]

## Operation
- Group g = {g2,g1,g0}, where g2 is the MSB.
- Digit encoding per output, using bit positions:
  - bit0 = neg = g2
  - bit1 = two = (g1 == g0) && (g1 != g2)
  - bit2 = one = g1 ^ g0
- Full group → digit mapping:
  - 000 → 000 (0)
  - 001 → 100 (+1)
  - 010 → 100 (+1)
  - 011 → 010 (+2)
  - 100 → 011 (−2)
  - 101 → 101 (−1)
  - 110 → 101 (−1)
  - 111 → 001 (−0; the neg bit must still be set)
- Value identity: with digit value d = (neg ? −1 : +1)·(2·two + one), the sum Σ d_i·4^i equals signed(x) for every x.
- Exactly one of one/two is set for a nonzero digit. Both are clear for a zero digit.
- The logic is purely combinational from x to the digit triples, followed by one register stage.

## Timing
- On a rising clk edge with rst=1:
  - sdn1..sdn4 ← 000
  - valid_out ← 0
  - rst has priority over valid_in.
- On a rising edge with rst=0 and valid_in=1:
  - sdn1..sdn4 ← encode(x)
  - valid_out ← 1
- On a rising edge with rst=0 and valid_in=0:
  - sdn1..sdn4 hold their previous value
  - valid_out ← 0
- Latency is 1 cycle. Throughput is one operand per cycle. There is no backpressure.
- Back-to-back valid inputs produce back-to-back results in order.
- Reset asserted mid-stream discards the in-flight result. The first valid_out after reset deasserts corresponds to the first valid_in sampled with rst=0.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold rst=1 with valid_in=1, x=0xFF → sdn1..4=000, valid_out=0. Release reset, apply x=0x0A → next cycle sdn1=011, sdn2=101, sdn3=100, sdn4=000, valid_out=1 (−2 −4 +16 = 10).
- x=0xFF → sdn1=101, sdn2=001, sdn3=001, sdn4=001 (−1, including negative zeros).
- x=0x80 → sdn1=000, sdn2=000, sdn3=000, sdn4=011 (−128).
- x=0x55 → all four = 100 (85). x=0x0F → sdn1=101, sdn2=001, sdn3=100, sdn4=000 (15).
- Hold/stream check: valid_in pulses 0x0A, then 0, then 0x0F.
  - Outputs update on cycles 1 and 3 with valid_out=1.
  - On cycle 2, outputs hold the 0x0A result with valid_out=0.
- Exhaustive: all 256 x values → each digit matches the mapping table, and Σ d_i·4^i == signed(x).

Source files
------------

// File: rtl/encoder_if.sv
// Operand/result bundle for the radix-4 Booth recoder: operand in, four registered digit triples out.
interface encoder_if;
  logic       valid_in;
  logic [7:0] x;
  logic       valid_out;
  logic [2:0] sdn1;
  logic [2:0] sdn2;
  logic [2:0] sdn3;
  logic [2:0] sdn4;

  modport master (
    output valid_in, x,
    input  valid_out, sdn1, sdn2, sdn3, sdn4
  );

  modport slave (
    input  valid_in, x,
    output valid_out, sdn1, sdn2, sdn3, sdn4
  );
endinterface

// File: rtl/encoder.sv
// Radix-4 modified Booth recoder for an 8-bit two's-complement operand.
// Each output triple is {one, two, neg}; the result is registered, giving one cycle of latency.
module encoder (
  input  logic      clk,
  input  logic      rst,
  encoder_if.slave  bus
);

  // Group {g2,g1,g0} -> {one, two, neg}; 111 keeps neg set (negative zero).
  function automatic logic [2:0] booth_digit(input logic [2:0] grp);
    logic [2:0] dig;
    case (grp)
      3'b000:  dig = 3'b000;
      3'b001:  dig = 3'b100;
      3'b010:  dig = 3'b100;
      3'b011:  dig = 3'b010;
      3'b100:  dig = 3'b011;
      3'b101:  dig = 3'b101;
      3'b110:  dig = 3'b101;
      3'b111:  dig = 3'b001;
      default: dig = 3'b000;
    endcase
    return dig;
  endfunction

  logic [2:0] dig0_s;
  logic [2:0] dig1_s;
  logic [2:0] dig2_s;
  logic [2:0] dig3_s;

  logic       valid_r;
  logic [2:0] dig0_r;
  logic [2:0] dig1_r;
  logic [2:0] dig2_r;
  logic [2:0] dig3_r;

  // Split the operand into four overlapping groups; the lowest group has an implied 0 below x[0].
  always_comb begin
    dig0_s = 3'b000;
    dig1_s = 3'b000;
    dig2_s = 3'b000;
    dig3_s = 3'b000;
    dig0_s = booth_digit({bus.x[1:0], 1'b0});
    dig1_s = booth_digit(bus.x[3:1]);
    dig2_s = booth_digit(bus.x[5:3]);
    dig3_s = booth_digit(bus.x[7:5]);
  end

  // Result register: reset clears, a valid operand loads, otherwise digits hold and valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      dig0_r  <= 3'b000;
      dig1_r  <= 3'b000;
      dig2_r  <= 3'b000;
      dig3_r  <= 3'b000;
    end else if (bus.valid_in) begin
      valid_r <= 1'b1;
      dig0_r  <= dig0_s;
      dig1_r  <= dig1_s;
      dig2_r  <= dig2_s;
      dig3_r  <= dig3_s;
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign bus.valid_out = valid_r;
  assign bus.sdn1      = dig0_r;
  assign bus.sdn2      = dig1_r;
  assign bus.sdn3      = dig2_r;
  assign bus.sdn4      = dig3_r;

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for the Booth recoder: directed vectors, exhaustive sweep and random stream
// against an arithmetic reference model.
module tb_encoder;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [2:0] exp_sdn [4];
  logic       exp_valid;
  logic [7:0] exp_x;

  encoder_if bus ();

  encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference digit: value = g1 + g0 - 2*g2; neg follows the group MSB even when the value is zero.
  function automatic logic [2:0] ref_digit(input logic [2:0] g);
    int v;
    int mag;
    v   = int'(g[1]) + int'(g[0]) - 2 * int'(g[2]);
    mag = (v < 0) ? -v : v;
    return {(mag == 1), (mag == 2), g[2]};
  endfunction

  function automatic int digit_val(input logic [2:0] d);
    int m;
    m = 2 * int'(d[1]) + int'(d[2]);
    return d[0] ? -m : m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then sample just after it.
  task automatic step(input logic r, input logic v, input logic [7:0] xv);
    logic [8:0] ext;
    @(negedge clk);
    rst          = r;
    bus.valid_in = v;
    bus.x        = xv;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 4; i++) exp_sdn[i] = 3'b000;
      exp_valid = 1'b0;
    end else if (v) begin
      ext = {xv, 1'b0};
      for (int i = 0; i < 4; i++) exp_sdn[i] = ref_digit(ext[2*i +: 3]);
      exp_valid = 1'b1;
      exp_x     = xv;
    end else begin
      exp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    int sum;
    int sx;
    check({tag, "_valid"}, 32'(bus.valid_out), 32'(exp_valid));
    check({tag, "_sdn1"},  32'(bus.sdn1), 32'(exp_sdn[0]));
    check({tag, "_sdn2"},  32'(bus.sdn2), 32'(exp_sdn[1]));
    check({tag, "_sdn3"},  32'(bus.sdn3), 32'(exp_sdn[2]));
    check({tag, "_sdn4"},  32'(bus.sdn4), 32'(exp_sdn[3]));
    if (exp_valid) begin
      sum = digit_val(bus.sdn1) + 4 * digit_val(bus.sdn2)
          + 16 * digit_val(bus.sdn3) + 64 * digit_val(bus.sdn4);
      sx  = int'($signed(exp_x));
      check({tag, "_sum"}, 32'(sum), 32'(sx));
    end
  endtask

  task automatic check_const(input string tag, input logic [2:0] e1, input logic [2:0] e2,
                             input logic [2:0] e3, input logic [2:0] e4, input logic ev);
    check({tag, "_valid"}, 32'(bus.valid_out), 32'(ev));
    check({tag, "_sdn1"},  32'(bus.sdn1), 32'(e1));
    check({tag, "_sdn2"},  32'(bus.sdn2), 32'(e2));
    check({tag, "_sdn3"},  32'(bus.sdn3), 32'(e3));
    check({tag, "_sdn4"},  32'(bus.sdn4), 32'(e4));
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    exp_valid    = 1'b0;
    exp_x        = 8'h00;
    for (int i = 0; i < 4; i++) exp_sdn[i] = 3'b000;
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.x        = 8'h00;

    // Reset wins over a valid operand.
    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'hFF);
    check_const("reset", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);

    // Directed vectors.
    step(1'b0, 1'b1, 8'h0A);
    check_const("x0a", 3'b011, 3'b101, 3'b100, 3'b000, 1'b1);
    step(1'b0, 1'b1, 8'hFF);
    check_const("xff", 3'b101, 3'b001, 3'b001, 3'b001, 1'b1);
    step(1'b0, 1'b1, 8'h80);
    check_const("x80", 3'b000, 3'b000, 3'b000, 3'b011, 1'b1);
    step(1'b0, 1'b1, 8'h55);
    check_const("x55", 3'b100, 3'b100, 3'b100, 3'b100, 1'b1);
    step(1'b0, 1'b1, 8'h0F);
    check_const("x0f", 3'b101, 3'b001, 3'b100, 3'b000, 1'b1);

    // Hold/stream: idle cycle keeps the previous digits with valid_out low.
    step(1'b0, 1'b1, 8'h0A);
    check_const("strm1", 3'b011, 3'b101, 3'b100, 3'b000, 1'b1);
    step(1'b0, 1'b0, 8'h0F);
    check_const("strm2", 3'b011, 3'b101, 3'b100, 3'b000, 1'b0);
    step(1'b0, 1'b1, 8'h0F);
    check_const("strm3", 3'b101, 3'b001, 3'b100, 3'b000, 1'b1);

    // Mid-stream reset discards the in-flight operand.
    step(1'b1, 1'b1, 8'h55);
    check_const("midrst", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    step(1'b0, 1'b0, 8'h55);
    check_const("postrst", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    step(1'b0, 1'b1, 8'h80);
    check_model("first");

    // Exhaustive back-to-back sweep of every operand.
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 1'b1, 8'(i));
      check_model("exh");
    end

    // Random stream with idle cycles and occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
